// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: operand forwarding, load-use stall, branch flush,
// halt/single-step debug FSM and a saturating load-use stall counter.
module hazard_ctrl #(
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned STEP_W = 8,
    parameter int unsigned PERF_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              debug_en,
    input  logic              debug_step,
    input  logic [STEP_W-1:0] debug_cnt,
    input  logic [ADDR_W-1:0] id_rs,
    input  logic [ADDR_W-1:0] id_rt,
    input  logic              id_rs_used,
    input  logic              id_rt_used,
    input  logic              exe_wen,
    input  logic [ADDR_W-1:0] exe_waddr,
    input  logic              exe_ren,
    input  logic              mem_wen,
    input  logic [ADDR_W-1:0] mem_waddr,
    input  logic              branch_taken,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic              if_en,
    output logic              id_en,
    output logic              if_flush,
    output logic              id_flush,
    output logic              cpu_rst,
    output logic              cpu_en,
    output logic [1:0]        dbg_state,
    output logic [PERF_W-1:0] stall_cnt
);

    typedef enum logic [1:0] {
        ST_RUN  = 2'b00,
        ST_HALT = 2'b01,
        ST_STEP = 2'b10
    } dbg_state_t;

    dbg_state_t        state, state_next;
    logic [STEP_W-1:0] step_cnt, step_cnt_next;
    logic              debug_step_q;
    logic              step_edge;

    logic exe_match_a, exe_match_b, mem_match_a, mem_match_b;
    logic load_use;

    // Operand/stage match; register 0 never matches
    assign exe_match_a = id_rs_used && exe_wen && (exe_waddr == id_rs) && (id_rs != '0);
    assign exe_match_b = id_rt_used && exe_wen && (exe_waddr == id_rt) && (id_rt != '0);
    assign mem_match_a = id_rs_used && mem_wen && (mem_waddr == id_rs) && (id_rs != '0);
    assign mem_match_b = id_rt_used && mem_wen && (mem_waddr == id_rt) && (id_rt != '0);

    assign load_use  = exe_ren && (exe_match_a || exe_match_b);
    assign step_edge = debug_step && !debug_step_q;

    assign cpu_rst   = rst;
    assign cpu_en    = !rst && (state != ST_HALT);
    assign dbg_state = state;

    // Forwarding select, EXE result has priority over MEM result
    always_comb begin
        fwd_a = 2'b00;
        fwd_b = 2'b00;
        if (exe_match_a)      fwd_a = 2'b01;
        else if (mem_match_a) fwd_a = 2'b10;
        if (exe_match_b)      fwd_b = 2'b01;
        else if (mem_match_b) fwd_b = 2'b10;
    end

    // Pipeline enables/flushes; branch redirect overrides a load-use stall
    always_comb begin
        if_en    = 1'b0;
        id_en    = 1'b0;
        if_flush = 1'b0;
        id_flush = 1'b0;
        if (cpu_en) begin
            if (branch_taken) begin
                if_en    = 1'b1;
                id_en    = 1'b1;
                if_flush = 1'b1;
                id_flush = 1'b1;
            end else if (load_use) begin
                id_flush = 1'b1;
            end else begin
                if_en = 1'b1;
                id_en = 1'b1;
            end
        end
    end

    // Debug FSM state, step counter and step-request history
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_RUN;
            step_cnt     <= '0;
            debug_step_q <= 1'b0;
        end else begin
            state        <= state_next;
            step_cnt     <= step_cnt_next;
            debug_step_q <= debug_step;
        end
    end

    // Debug FSM next state; leaving debug mode wins over step expiry
    always_comb begin
        state_next    = state;
        step_cnt_next = step_cnt;
        case (state)
            ST_RUN: begin
                step_cnt_next = '0;
                if (debug_en) state_next = ST_HALT;
            end
            ST_HALT: begin
                if (!debug_en) begin
                    state_next = ST_RUN;
                end else if (step_edge) begin
                    state_next    = ST_STEP;
                    step_cnt_next = (debug_cnt == '0) ? STEP_W'(1) : debug_cnt;
                end
            end
            ST_STEP: begin
                step_cnt_next = step_cnt - STEP_W'(1);
                if (!debug_en)                    state_next = ST_RUN;
                else if (step_cnt == STEP_W'(1))  state_next = ST_HALT;
            end
            default: begin
                state_next    = ST_RUN;
                step_cnt_next = '0;
            end
        endcase
    end

    // Saturating count of effective load-use stall cycles
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (load_use && cpu_en && !branch_taken && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + PERF_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: forwarding, stalls, branch flush, debug stepping.
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       debug_en, debug_step;
    logic [7:0] debug_cnt;
    logic [4:0] id_rs, id_rt, exe_waddr, mem_waddr;
    logic       id_rs_used, id_rt_used, exe_wen, exe_ren, mem_wen, branch_taken;

    logic [1:0]  fwd_a, fwd_b, dbg_state;
    logic        if_en, id_en, if_flush, id_flush, cpu_rst, cpu_en;
    logic [15:0] stall_cnt;

    logic [1:0] s_fwd_a, s_fwd_b, s_dbg_state;
    logic       s_if_en, s_id_en, s_if_flush, s_id_flush, s_cpu_rst, s_cpu_en;
    logic [1:0] s_stall_cnt;

    int total = 0;
    int bad   = 0;
    int on_cycles;

    always #5 clk = ~clk;

    hazard_ctrl dut (
        .clk(clk), .rst(rst), .debug_en(debug_en), .debug_step(debug_step),
        .debug_cnt(debug_cnt), .id_rs(id_rs), .id_rt(id_rt),
        .id_rs_used(id_rs_used), .id_rt_used(id_rt_used),
        .exe_wen(exe_wen), .exe_waddr(exe_waddr), .exe_ren(exe_ren),
        .mem_wen(mem_wen), .mem_waddr(mem_waddr), .branch_taken(branch_taken),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .if_en(if_en), .id_en(id_en),
        .if_flush(if_flush), .id_flush(id_flush), .cpu_rst(cpu_rst),
        .cpu_en(cpu_en), .dbg_state(dbg_state), .stall_cnt(stall_cnt)
    );

    hazard_ctrl #(.PERF_W(2)) dut_small (
        .clk(clk), .rst(rst), .debug_en(debug_en), .debug_step(debug_step),
        .debug_cnt(debug_cnt), .id_rs(id_rs), .id_rt(id_rt),
        .id_rs_used(id_rs_used), .id_rt_used(id_rt_used),
        .exe_wen(exe_wen), .exe_waddr(exe_waddr), .exe_ren(exe_ren),
        .mem_wen(mem_wen), .mem_waddr(mem_waddr), .branch_taken(branch_taken),
        .fwd_a(s_fwd_a), .fwd_b(s_fwd_b), .if_en(s_if_en), .id_en(s_id_en),
        .if_flush(s_if_flush), .id_flush(s_id_flush), .cpu_rst(s_cpu_rst),
        .cpu_en(s_cpu_en), .dbg_state(s_dbg_state), .stall_cnt(s_stall_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_pipe();
        id_rs = '0; id_rt = '0; id_rs_used = 0; id_rt_used = 0;
        exe_wen = 0; exe_waddr = '0; exe_ren = 0;
        mem_wen = 0; mem_waddr = '0; branch_taken = 0;
    endtask

    task automatic set_load_use();
        exe_ren = 1; exe_wen = 1; exe_waddr = 5'd3;
        id_rs = 5'd3; id_rs_used = 1;
    endtask

    // Count cpu_en-high cycles over a fixed window starting in the current cycle
    task automatic count_run(input int window, output int n);
        n = 0;
        for (int i = 0; i < window; i++) begin
            if (cpu_en) n++;
            tick();
        end
    endtask

    initial begin
        rst = 1; debug_en = 0; debug_step = 0; debug_cnt = '0;
        clear_pipe();
        tick(); tick();
        check("rst_cpu_rst",   32'(cpu_rst),   32'd1);
        check("rst_cpu_en",    32'(cpu_en),    32'd0);
        check("rst_state",     32'(dbg_state), 32'd0);
        check("rst_stall",     32'(stall_cnt), 32'd0);
        check("rst_if_en",     32'(if_en),     32'd0);

        rst = 0;
        tick();
        check("run_cpu_rst", 32'(cpu_rst), 32'd0);
        check("run_cpu_en",  32'(cpu_en),  32'd1);
        check("run_if_en",   32'(if_en),   32'd1);

        // load-use stall on rs=3
        set_load_use(); #1;
        check("lu_if_en",    32'(if_en),    32'd0);
        check("lu_id_en",    32'(id_en),    32'd0);
        check("lu_id_flush", 32'(id_flush), 32'd1);
        check("lu_if_flush", 32'(if_flush), 32'd0);
        check("lu_fwd_a",    32'(fwd_a),    32'd1);
        tick();
        clear_pipe(); #1;
        check("lu_stall1",   32'(stall_cnt), 32'd1);
        check("lu_after_if", 32'(if_en),     32'd1);
        check("lu_after_fl", 32'(id_flush),  32'd0);

        // forwarding priority on rt=4
        exe_wen = 1; exe_waddr = 5'd4; mem_wen = 1; mem_waddr = 5'd4;
        id_rt = 5'd4; id_rt_used = 1; #1;
        check("fwd_exe", 32'(fwd_b), 32'd1);
        exe_waddr = 5'd0; #1;
        check("fwd_mem", 32'(fwd_b), 32'd2);
        mem_waddr = 5'd0; #1;
        check("fwd_none", 32'(fwd_b), 32'd0);
        exe_waddr = 5'd4; mem_waddr = 5'd4; id_rt_used = 0; #1;
        check("fwd_unused", 32'(fwd_b), 32'd0);
        exe_wen = 0; #1;
        id_rt_used = 1; #1;
        check("fwd_exe_nowen", 32'(fwd_b), 32'd2);
        // register 0 never forwards or stalls
        clear_pipe();
        exe_wen = 1; exe_ren = 1; mem_wen = 1; id_rt_used = 1; id_rs_used = 1; #1;
        check("r0_fwd_a", 32'(fwd_a), 32'd0);
        check("r0_fwd_b", 32'(fwd_b), 32'd0);
        check("r0_nostall", 32'(if_en), 32'd1);
        clear_pipe();

        // branch overrides load-use
        set_load_use(); branch_taken = 1; #1;
        check("br_if_flush", 32'(if_flush), 32'd1);
        check("br_id_flush", 32'(id_flush), 32'd1);
        check("br_if_en",    32'(if_en),    32'd1);
        check("br_id_en",    32'(id_en),    32'd1);
        tick();
        check("br_stall_same", 32'(stall_cnt), 32'd1);

        // five more stalls: wide counter 6, 2-bit counter saturates at 3
        branch_taken = 0;
        for (int i = 0; i < 5; i++) tick();
        clear_pipe(); #1;
        check("sat_wide",  32'(stall_cnt),   32'd6);
        check("sat_small", 32'(s_stall_cnt), 32'd3);

        // halt, then step 3 while holding debug_step high
        debug_en = 1;
        tick();
        check("halt_state",  32'(dbg_state), 32'd1);
        check("halt_cpu_en", 32'(cpu_en),    32'd0);
        check("halt_if_en",  32'(if_en),     32'd0);
        set_load_use(); tick(); clear_pipe(); #1;
        check("halt_nostall", 32'(stall_cnt), 32'd6);
        debug_cnt = 8'd3; debug_step = 1;
        tick();
        check("step_state", 32'(dbg_state), 32'd2);
        count_run(8, on_cycles);
        check("step3_cycles", 32'(on_cycles), 32'd3);
        check("step3_halt",   32'(dbg_state), 32'd1);

        // step of zero runs one cycle
        debug_step = 0; tick();
        debug_cnt = 8'd0; debug_step = 1;
        tick();
        count_run(6, on_cycles);
        check("step0_cycles", 32'(on_cycles), 32'd1);
        check("step0_halt",   32'(dbg_state), 32'd1);
        debug_step = 0;

        // leaving debug mode mid-step returns to RUN
        tick();
        debug_cnt = 8'd5; debug_step = 1;
        tick();
        debug_step = 0; debug_en = 0;
        tick();
        check("step_abort_run", 32'(dbg_state), 32'd0);
        debug_step = 1; tick(); tick();
        check("run_ignores_step", 32'(dbg_state), 32'd0);
        debug_step = 0;

        // reset during STEP aborts the step and clears the counter
        debug_en = 1; tick();
        debug_cnt = 8'd10; debug_step = 1; tick();
        check("pre_rst_step", 32'(dbg_state), 32'd2);
        rst = 1; tick();
        check("mid_rst_state", 32'(dbg_state), 32'd0);
        check("mid_rst_stall", 32'(stall_cnt), 32'd0);
        check("mid_rst_cpuen", 32'(cpu_en),    32'd0);
        rst = 0; tick(); tick();
        check("post_rst_halt", 32'(dbg_state), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter ADDR_W, default 5, sets the width of the register-address fields.
REQ-002 Parameter STEP_W, default 8, sets the width of the debug step count.
REQ-003 Parameter PERF_W, default 16, sets the width of the stall performance counter.
REQ-004 clk  input  1  main clock; all state updates on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 debug_en  input  1  requests halt/step debug mode.
REQ-007 debug_step  input  1  raw step request; only its rising edge is used.
REQ-008 debug_cnt  input  STEP_W  cycles to run per step request; 0 is treated as 1.
REQ-009 id_rs, id_rt  input  ADDR_W each  source registers of the instruction in ID.
REQ-010 id_rs_used, id_rt_used  input  1 each  the ID instruction actually reads rs / rt.
REQ-011 exe_wen, exe_waddr, exe_ren  input  1/ADDR_W/1  EXE-stage write-back enable, destination, load flag.
REQ-012 mem_wen, mem_waddr  input  1/ADDR_W  MEM-stage write-back enable, destination.
REQ-013 branch_taken  input  1  the branch or jump resolved in EXE redirects the PC.
REQ-014 fwd_a, fwd_b  output  2 each  operand source: 00 regfile, 01 EXE result, 10 MEM result.
REQ-015 if_en, id_en  output  1 each  IF/ID pipeline register enables.
REQ-016 if_flush, id_flush  output  1 each  insert a bubble into ID / EXE.
REQ-017 cpu_rst, cpu_en  output  1 each  pipeline reset and global enable.
REQ-018 dbg_state  output  2  debug FSM state: 00 RUN, 01 HALT, 10 STEP.
REQ-019 stall_cnt  output  PERF_W  saturating count of load-use stall cycles.

Function
REQ-020 Forwarding SHALL be combinational; the EXE match SHALL take priority over the MEM match.
REQ-021 An operand matches a stage when: the operand is used, the stage's wen=1, the addresses are equal, and the address is nonzero.
REQ-022 Register 0 SHALL never cause forwarding or a stall.
REQ-023 Load-use hazard: exe_ren=1 and a used ID operand matches exe_waddr (nonzero).
REQ-024 Load-use stall: if_en=0, id_en=0, id_flush=1 for exactly one cycle.
REQ-025 branch_taken=1: if_flush=1 and id_flush=1; if_en=1 and id_en=1.
REQ-026 branch_taken SHALL override a simultaneous load-use stall.
REQ-027 cpu_rst SHALL equal rst combinationally.
REQ-028 cpu_en=1 in RUN and in STEP; cpu_en=0 in HALT and while rst=1.
REQ-029 When cpu_en=0: if_en, id_en, if_flush and id_flush SHALL all be 0.
REQ-030 Edge detection: step_edge = debug_step & ~debug_step_q, where debug_step_q is a registered copy of debug_step.
REQ-031 Transition RUN->HALT when debug_en=1.
REQ-032 Transition HALT->RUN when debug_en=0.
REQ-033 Transition HALT->STEP on step_edge; the step counter loads max(debug_cnt,1).
REQ-034 In STEP the counter SHALL decrement every cycle.
REQ-035 STEP->HALT on the cycle the counter equals 1.
REQ-036 STEP->RUN if debug_en=0; debug_en=0 takes priority over counter expiry.
REQ-037 step_edge while in STEP or RUN SHALL be ignored; the counter is not reloaded.
REQ-038 stall_cnt SHALL increment on each load-use stall cycle with cpu_en=1 and branch_taken=0.
REQ-039 stall_cnt SHALL saturate at all-ones.

Reset
REQ-040 While rst=1: dbg_state=RUN, step counter=0, debug_step_q=0, stall_cnt=0, cpu_rst=1, cpu_en=0.
REQ-041 An rst asserted mid-STEP SHALL abort the step on the next edge; the step is not resumed after reset.

Verification
REQ-042 Load-use: exe_ren=1, exe_wen=1, exe_waddr=3; id_rs=3, id_rs_used=1 -> one stall cycle (if_en=0, id_en=0, id_flush=1); stall_cnt 0->1.
REQ-043 Priority: exe_waddr=4 and mem_waddr=4, both wen=1, id_rt=4 used -> fwd_b=01; with exe_waddr=0 -> fwd_b=10; with addresses 0 -> fwd_b=00.
REQ-044 Branch vs stall: branch_taken together with a load-use hazard -> if_flush=1, id_flush=1, if_en=1, stall_cnt unchanged.
REQ-045 Step: debug_en=1, then debug_cnt=3 and a debug_step pulse -> cpu_en high exactly 3 cycles, then dbg_state=HALT; holding debug_step high gives no retrigger.
REQ-046 Step of zero: debug_cnt=0 step -> cpu_en high exactly 1 cycle.
REQ-047 Saturation and reset: PERF_W=2 with 5 stalls -> stall_cnt=3; rst during STEP -> RUN with stall_cnt=0 the next cycle.
